// File: rtl/nn_acc_pkg.sv
// Shared types, widths, config address map and power-on parameter defaults
// for the time-multiplexed 4-input / 3-neuron network.
package nn_acc_pkg;

    localparam int DATA_W    = 8;
    localparam int BIAS_W    = 16;
    localparam int CLAMP_W   = 12;
    localparam int CNT_W     = 16;
    localparam int N_NEURONS = 3;
    localparam int N_STRIDE  = 8;

    localparam logic [2:0] OFF_W1   = 3'd0;
    localparam logic [2:0] OFF_W2   = 3'd1;
    localparam logic [2:0] OFF_W3   = 3'd2;
    localparam logic [2:0] OFF_W4   = 3'd3;
    localparam logic [2:0] OFF_BIAS = 3'd4;
    localparam logic [2:0] OFF_XMIN = 3'd5;
    localparam logic [2:0] OFF_XMAX = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EVAL1,
        ST_EVAL2,
        ST_EVAL3,
        ST_OUT
    } state_e;

    localparam int DEF_W [N_NEURONS][4] = '{
        '{-115,   1, -105,  16},
        '{ 103, -22,   32, -56},
        '{  75, -85,  -38,  92}
    };
    localparam int DEF_BIAS [N_NEURONS] = '{12571, -8139, 10182};
    localparam int DEF_XMIN = -127;
    localparam int DEF_XMAX = 127;

    // Neuron field 3 and offset 7 are holes in the map.
    function automatic logic cfg_mapped(input logic [4:0] addr);
        return (addr[4:3] != 2'd3) && (addr[2:0] != 3'd7);
    endfunction

endpackage

// File: rtl/nn_param_regfile.sv
// Per-neuron parameter bank: reset defaults, config write decode with a
// registered reject pulse, and a read port selected by the active neuron.
module nn_param_regfile
    import nn_acc_pkg::*;
#(
    parameter int DATA_W  = nn_acc_pkg::DATA_W,
    parameter int BIAS_W  = nn_acc_pkg::BIAS_W,
    parameter int CLAMP_W = nn_acc_pkg::CLAMP_W
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      cfg_we,
    input  logic [4:0]                cfg_addr,
    input  logic [15:0]               cfg_wdata,
    input  logic                      cfg_open,
    output logic                      cfg_err,
    input  logic [1:0]                sel,
    output logic signed [DATA_W-1:0]  w1,
    output logic signed [DATA_W-1:0]  w2,
    output logic signed [DATA_W-1:0]  w3,
    output logic signed [DATA_W-1:0]  w4,
    output logic signed [BIAS_W-1:0]  bias,
    output logic signed [CLAMP_W-1:0] xmin,
    output logic signed [CLAMP_W-1:0] xmax
);

    logic signed [DATA_W-1:0]  w_q    [N_NEURONS][4];
    logic signed [BIAS_W-1:0]  bias_q [N_NEURONS];
    logic signed [CLAMP_W-1:0] xmin_q [N_NEURONS];
    logic signed [CLAMP_W-1:0] xmax_q [N_NEURONS];
    logic                      err_q;

    logic [1:0] wr_n;
    logic [2:0] wr_off;
    logic       wr_ok;
    logic [1:0] rd_n;

    assign wr_n   = cfg_addr[4:3];
    assign wr_off = cfg_addr[2:0];
    assign wr_ok  = cfg_we && cfg_open && cfg_mapped(cfg_addr);
    assign rd_n   = sel - 2'd1;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int n = 0; n < N_NEURONS; n++) begin
                for (int i = 0; i < 4; i++) begin
                    w_q[n][i] <= DATA_W'(DEF_W[n][i]);
                end
                bias_q[n] <= BIAS_W'(DEF_BIAS[n]);
                xmin_q[n] <= CLAMP_W'(DEF_XMIN);
                xmax_q[n] <= CLAMP_W'(DEF_XMAX);
            end
            err_q <= 1'b0;
        end else begin
            err_q <= cfg_we && !wr_ok;
            if (wr_ok) begin
                case (wr_off)
                    OFF_W1, OFF_W2, OFF_W3, OFF_W4:
                        w_q[wr_n][wr_off[1:0]] <= cfg_wdata[DATA_W-1:0];
                    OFF_BIAS: bias_q[wr_n] <= cfg_wdata[BIAS_W-1:0];
                    OFF_XMIN: xmin_q[wr_n] <= cfg_wdata[CLAMP_W-1:0];
                    OFF_XMAX: xmax_q[wr_n] <= cfg_wdata[CLAMP_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign cfg_err = err_q;

    // sel==0 means no neuron is active, so the bus is parked at zero.
    always_comb begin
        w1   = '0;
        w2   = '0;
        w3   = '0;
        w4   = '0;
        bias = '0;
        xmin = '0;
        xmax = '0;
        if (sel != 2'd0) begin
            w1   = w_q[rd_n][0];
            w2   = w_q[rd_n][1];
            w3   = w_q[rd_n][2];
            w4   = w_q[rd_n][3];
            bias = bias_q[rd_n];
            xmin = xmin_q[rd_n];
            xmax = xmax_q[rd_n];
        end
    end

endmodule

// File: rtl/nn_layer_scheduler.sv
// Sequencer sharing one combinational neuron across N1, N2 (hidden) and N3
// (output), with valid/ready on both sides and a writable parameter bank.
module nn_layer_scheduler
    import nn_acc_pkg::*;
#(
    parameter int DATA_W  = nn_acc_pkg::DATA_W,
    parameter int BIAS_W  = nn_acc_pkg::BIAS_W,
    parameter int CLAMP_W = nn_acc_pkg::CLAMP_W,
    parameter int CNT_W   = nn_acc_pkg::CNT_W
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic signed [DATA_W-1:0]  x1,
    input  logic signed [DATA_W-1:0]  x2,
    input  logic signed [DATA_W-1:0]  x3,
    input  logic signed [DATA_W-1:0]  x4,
    input  logic                      valid,
    output logic                      ready,
    output logic signed [DATA_W-1:0]  y,
    output logic                      valid_out,
    input  logic                      ready_out,
    input  logic                      cfg_we,
    input  logic [4:0]                cfg_addr,
    input  logic [15:0]               cfg_wdata,
    output logic                      cfg_err,
    output logic [1:0]                n_sel,
    output logic signed [DATA_W-1:0]  n_x1,
    output logic signed [DATA_W-1:0]  n_x2,
    output logic signed [DATA_W-1:0]  n_x3,
    output logic signed [DATA_W-1:0]  n_x4,
    output logic signed [DATA_W-1:0]  n_w1,
    output logic signed [DATA_W-1:0]  n_w2,
    output logic signed [DATA_W-1:0]  n_w3,
    output logic signed [DATA_W-1:0]  n_w4,
    output logic signed [BIAS_W-1:0]  n_bias,
    output logic signed [CLAMP_W-1:0] n_xmin,
    output logic signed [CLAMP_W-1:0] n_xmax,
    input  logic signed [DATA_W-1:0]  n_y,
    output logic                      busy,
    output logic [CNT_W-1:0]          frame_cnt
);

    state_e                   state_q;
    logic signed [DATA_W-1:0] x1_q, x2_q, x3_q, x4_q;
    logic signed [DATA_W-1:0] s1_q, s2_q, y_q;
    logic                     valid_out_q;
    logic [CNT_W-1:0]         frame_cnt_q;
    logic                     accept;

    assign ready  = (state_q == ST_IDLE) || ((state_q == ST_OUT) && ready_out);
    assign accept = valid && ready;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= ST_IDLE;
            x1_q        <= '0;
            x2_q        <= '0;
            x3_q        <= '0;
            x4_q        <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            y_q         <= '0;
            valid_out_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        {x1_q, x2_q, x3_q, x4_q} <= {x1, x2, x3, x4};
                        state_q <= ST_EVAL1;
                    end
                end
                ST_EVAL1: begin
                    s1_q    <= n_y;
                    state_q <= ST_EVAL2;
                end
                ST_EVAL2: begin
                    s2_q    <= n_y;
                    state_q <= ST_EVAL3;
                end
                ST_EVAL3: begin
                    y_q         <= n_y;
                    valid_out_q <= 1'b1;
                    state_q     <= ST_OUT;
                end
                ST_OUT: begin
                    // A new sample may be taken on the same edge the result leaves.
                    if (ready_out) begin
                        valid_out_q <= 1'b0;
                        frame_cnt_q <= frame_cnt_q + 1'b1;
                        if (accept) begin
                            {x1_q, x2_q, x3_q, x4_q} <= {x1, x2, x3, x4};
                            state_q <= ST_EVAL1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign y         = y_q;
    assign valid_out = valid_out_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        n_sel = 2'd0;
        n_x1  = '0;
        n_x2  = '0;
        n_x3  = '0;
        n_x4  = '0;
        case (state_q)
            ST_EVAL1, ST_EVAL2: begin
                n_sel = (state_q == ST_EVAL1) ? 2'd1 : 2'd2;
                n_x1  = x1_q;
                n_x2  = x2_q;
                n_x3  = x3_q;
                n_x4  = x4_q;
            end
            ST_EVAL3: begin
                n_sel = 2'd3;
                n_x1  = s1_q;
                n_x2  = s2_q;
            end
            default: ;
        endcase
    end

    nn_param_regfile #(
        .DATA_W  (DATA_W),
        .BIAS_W  (BIAS_W),
        .CLAMP_W (CLAMP_W)
    ) u_params (
        .clk       (clk),
        .arst      (arst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_open  ((state_q == ST_IDLE) && !valid),
        .cfg_err   (cfg_err),
        .sel       (n_sel),
        .w1        (n_w1),
        .w2        (n_w2),
        .w3        (n_w3),
        .w4        (n_w4),
        .bias      (n_bias),
        .xmin      (n_xmin),
        .xmax      (n_xmax)
    );

endmodule

// File: tb/tb_nn_layer_scheduler.sv
// Directed bench for nn_layer_scheduler with a small behavioural stand-in
// for the shared neuron.
module tb_nn_layer_scheduler;

    logic               clk = 1'b0;
    logic               arst = 1'b1;
    logic signed [7:0]  x1 = '0, x2 = '0, x3 = '0, x4 = '0;
    logic               valid = 1'b0;
    logic               ready;
    logic signed [7:0]  y;
    logic               valid_out;
    logic               ready_out = 1'b0;
    logic               cfg_we = 1'b0;
    logic [4:0]         cfg_addr = '0;
    logic [15:0]        cfg_wdata = '0;
    logic               cfg_err;
    logic [1:0]         n_sel;
    logic signed [7:0]  n_x1, n_x2, n_x3, n_x4;
    logic signed [7:0]  n_w1, n_w2, n_w3, n_w4;
    logic signed [15:0] n_bias;
    logic signed [11:0] n_xmin, n_xmax;
    logic signed [7:0]  n_y;
    logic               busy;
    logic [15:0]        frame_cnt;

    int total = 0;
    int bad = 0;
    int mode = 0;
    logic [15:0] exp_cnt = '0;

    always #5 clk = ~clk;

    // mode 0: fixed 10/20/30 per neuron; mode 1: N1 passes x1, N2 passes x2, N3 adds.
    always_comb begin
        n_y = '0;
        if (mode == 0) begin
            case (n_sel)
                2'd1: n_y = 8'sd10;
                2'd2: n_y = 8'sd20;
                2'd3: n_y = 8'sd30;
                default: n_y = '0;
            endcase
        end else begin
            case (n_sel)
                2'd1: n_y = n_x1;
                2'd2: n_y = n_x2;
                2'd3: n_y = 8'(n_x1 + n_x2);
                default: n_y = '0;
            endcase
        end
    end

    nn_layer_scheduler dut (
        .clk(clk), .arst(arst),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4),
        .valid(valid), .ready(ready),
        .y(y), .valid_out(valid_out), .ready_out(ready_out),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
        .n_sel(n_sel),
        .n_x1(n_x1), .n_x2(n_x2), .n_x3(n_x3), .n_x4(n_x4),
        .n_w1(n_w1), .n_w2(n_w2), .n_w3(n_w3), .n_w4(n_w4),
        .n_bias(n_bias), .n_xmin(n_xmin), .n_xmax(n_xmax),
        .n_y(n_y), .busy(busy), .frame_cnt(frame_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
        tick();
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid_out got=%0d exp=0", valid_out); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0d exp=1", ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0d exp=0", busy); end
        total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL rst_frame_cnt got=%0d exp=0", frame_cnt); end
        total++; if (y !== 8'sd0) begin bad++; $display("FAIL rst_y got=%0d exp=0", y); end
        total++; if (n_sel !== 2'd0 || n_w1 !== 8'sd0) begin bad++; $display("FAIL rst_nbus got sel=%0d w1=%0d exp 0/0", n_sel, n_w1); end
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL rst_cfg_err got=%0d exp=0", cfg_err); end
    endtask

    task automatic test_defaults();
        mode = 0;
        ready_out = 1'b1;
        {x1, x2, x3, x4} = {8'sd1, 8'sd2, 8'sd3, 8'sd4};
        valid = 1'b1;
        tick();
        valid = 1'b0;
        total++; if (n_sel !== 2'd1) begin bad++; $display("FAIL def_sel1 got=%0d exp=1", n_sel); end
        total++; if (n_w1 !== -8'sd115 || n_w2 !== 8'sd1 || n_w3 !== -8'sd105 || n_w4 !== 8'sd16)
            begin bad++; $display("FAIL def_n1_w got=%0d,%0d,%0d,%0d exp=-115,1,-105,16", n_w1, n_w2, n_w3, n_w4); end
        total++; if (n_bias !== 16'sd12571) begin bad++; $display("FAIL def_n1_bias got=%0d exp=12571", n_bias); end
        total++; if (n_xmin !== -12'sd127 || n_xmax !== 12'sd127)
            begin bad++; $display("FAIL def_clamp got=%0d/%0d exp=-127/127", n_xmin, n_xmax); end
        total++; if (n_x1 !== 8'sd1 || n_x4 !== 8'sd4) begin bad++; $display("FAIL def_nx got=%0d,%0d exp=1,4", n_x1, n_x4); end
        tick();
        total++; if (n_sel !== 2'd2 || n_w1 !== 8'sd103 || n_bias !== -16'sd8139)
            begin bad++; $display("FAIL def_n2 got sel=%0d w1=%0d bias=%0d exp 2/103/-8139", n_sel, n_w1, n_bias); end
        tick();
        total++; if (n_sel !== 2'd3) begin bad++; $display("FAIL def_sel3 got=%0d exp=3", n_sel); end
        total++; if (n_w1 !== 8'sd75 || n_w2 !== -8'sd85 || n_w3 !== -8'sd38 || n_w4 !== 8'sd92)
            begin bad++; $display("FAIL def_n3_w got=%0d,%0d,%0d,%0d exp=75,-85,-38,92", n_w1, n_w2, n_w3, n_w4); end
        total++; if (n_bias !== 16'sd10182) begin bad++; $display("FAIL def_n3_bias got=%0d exp=10182", n_bias); end
        total++; if (n_x1 !== 8'sd10 || n_x2 !== 8'sd20 || n_x3 !== 8'sd0 || n_x4 !== 8'sd0)
            begin bad++; $display("FAIL def_n3_x got=%0d,%0d,%0d,%0d exp=10,20,0,0", n_x1, n_x2, n_x3, n_x4); end
        tick();
        total++; if (n_sel !== 2'd0 || n_w1 !== 8'sd0 || n_x1 !== 8'sd0)
            begin bad++; $display("FAIL def_out_bus got sel=%0d w1=%0d x1=%0d exp 0", n_sel, n_w1, n_x1); end
        tick();
        exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic test_single_frame();
        mode = 0;
        ready_out = 1'b1;
        {x1, x2, x3, x4} = {8'sd7, -8'sd7, 8'sd0, 8'sd1};
        valid = 1'b1;
        tick();
        valid = 1'b0;
        // Counting the accept edge as the first, valid_out rises on the fourth.
        for (int e = 1; e <= 3; e++) begin
            total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL sf_early_valid edge=%0d got=%0d exp=0", e, valid_out); end
            tick();
        end
        total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL sf_valid_out got=%0d exp=1", valid_out); end
        total++; if (y !== 8'sd30) begin bad++; $display("FAIL sf_y got=%0d exp=30", y); end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        total++; if (frame_cnt !== exp_cnt) begin bad++; $display("FAIL sf_frame_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
        total++; if (valid_out !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL sf_idle got vo=%0d busy=%0d exp 0/0", valid_out, busy); end
    endtask

    task automatic test_backpressure();
        mode = 0;
        ready_out = 1'b0;
        {x1, x2, x3, x4} = {8'sd3, 8'sd3, 8'sd3, 8'sd3};
        valid = 1'b1;
        tick();
        valid = 1'b0;
        repeat (3) tick();
        for (int c = 0; c < 5; c++) begin
            total++; if (valid_out !== 1'b1 || y !== 8'sd30)
                begin bad++; $display("FAIL bp_hold c=%0d got vo=%0d y=%0d exp 1/30", c, valid_out, y); end
            total++; if (ready !== 1'b0) begin bad++; $display("FAIL bp_ready c=%0d got=%0d exp=0", c, ready); end
            total++; if (frame_cnt !== exp_cnt) begin bad++; $display("FAIL bp_cnt c=%0d got=%0d exp=%0d", c, frame_cnt, exp_cnt); end
            tick();
        end
        ready_out = 1'b1;
        tick();
        exp_cnt = exp_cnt + 16'd1;
        total++; if (frame_cnt !== exp_cnt) begin bad++; $display("FAIL bp_release_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
        total++; if (valid_out !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL bp_release got vo=%0d rdy=%0d exp 0/1", valid_out, ready); end
    endtask

    task automatic test_back_to_back();
        logic signed [7:0] sa [3];
        logic signed [7:0] sb [3];
        logic signed [7:0] ey [3];
        sa[0] = 8'sd5;   sb[0] = 8'sd6;  ey[0] = 8'sd11;
        sa[1] = 8'sd7;   sb[1] = -8'sd3; ey[1] = 8'sd4;
        sa[2] = -8'sd20; sb[2] = 8'sd4;  ey[2] = -8'sd16;
        mode = 1;
        ready_out = 1'b1;
        {x1, x2, x3, x4} = {sa[0], sb[0], 8'sd0, 8'sd0};
        valid = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL b2b_eval2_vo i=%0d got=%0d exp=0", i, valid_out); end
            tick();
            total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL b2b_eval3_vo i=%0d got=%0d exp=0", i, valid_out); end
            tick();
            total++; if (valid_out !== 1'b1 || y !== ey[i])
                begin bad++; $display("FAIL b2b_out i=%0d got vo=%0d y=%0d exp 1/%0d", i, valid_out, y, ey[i]); end
            total++; if (ready !== 1'b1) begin bad++; $display("FAIL b2b_ready i=%0d got=%0d exp=1", i, ready); end
            if (i < 2) {x1, x2} = {sa[i+1], sb[i+1]};
            else valid = 1'b0;
            tick();
            total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL b2b_after_vo i=%0d got=%0d exp=0", i, valid_out); end
            if (i < 2) begin
                total++; if (n_sel !== 2'd1 || n_x1 !== sa[i+1])
                    begin bad++; $display("FAIL b2b_next i=%0d got sel=%0d x1=%0d exp 1/%0d", i, n_sel, n_x1, sa[i+1]); end
            end
        end
        exp_cnt = exp_cnt + 16'd3;
        total++; if (frame_cnt !== exp_cnt) begin bad++; $display("FAIL b2b_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%0d exp=0", busy); end
    endtask

    task automatic test_config();
        mode = 0;
        ready_out = 1'b1;
        cfg_we = 1'b1; cfg_addr = 5'h02; cfg_wdata = 16'h00CE;
        tick();
        cfg_we = 1'b0;
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_ok_err got=%0d exp=0", cfg_err); end
        {x1, x2, x3, x4} = {8'sd1, 8'sd1, 8'sd1, 8'sd1};
        valid = 1'b1;
        tick();
        valid = 1'b0;
        total++; if (n_w3 !== -8'sd50) begin bad++; $display("FAIL cfg_w3 got=%0d exp=-50", n_w3); end
        tick();
        cfg_we = 1'b1; cfg_addr = 5'h0C; cfg_wdata = 16'h0055;
        tick();
        cfg_we = 1'b0;
        total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_busy_err got=%0d exp=1", cfg_err); end
        tick();
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_busy_pulse got=%0d exp=0", cfg_err); end
        tick();
        cfg_we = 1'b1; cfg_addr = 5'h1F; cfg_wdata = 16'h0001;
        tick();
        cfg_we = 1'b0;
        total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_unmapped_err got=%0d exp=1", cfg_err); end
        tick();
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_unmapped_pulse got=%0d exp=0", cfg_err); end
        // Write coinciding with an accepted sample loses to the accept.
        cfg_we = 1'b1; cfg_addr = 5'h00; cfg_wdata = 16'h0011;
        valid = 1'b1;
        tick();
        cfg_we = 1'b0;
        valid = 1'b0;
        total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_accept_err got=%0d exp=1", cfg_err); end
        total++; if (n_w1 !== -8'sd115) begin bad++; $display("FAIL cfg_accept_w1 got=%0d exp=-115", n_w1); end
        tick();
        total++; if (n_bias !== -16'sd8139) begin bad++; $display("FAIL cfg_n2_bias got=%0d exp=-8139", n_bias); end
        repeat (3) tick();
        exp_cnt = exp_cnt + 16'd2;
        total++; if (frame_cnt !== exp_cnt) begin bad++; $display("FAIL cfg_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        mode = 0;
        ready_out = 1'b1;
        cfg_we = 1'b1; cfg_addr = 5'h00; cfg_wdata = 16'h0005;
        tick();
        cfg_we = 1'b0;
        {x1, x2, x3, x4} = {8'sd2, 8'sd2, 8'sd2, 8'sd2};
        valid = 1'b1;
        tick();
        valid = 1'b0;
        total++; if (n_w1 !== 8'sd5) begin bad++; $display("FAIL rm_w1_written got=%0d exp=5", n_w1); end
        tick();
        arst = 1'b1;
        #2;
        total++; if (busy !== 1'b0 || valid_out !== 1'b0) begin bad++; $display("FAIL rm_async got busy=%0d vo=%0d exp 0/0", busy, valid_out); end
        @(negedge clk);
        arst = 1'b0;
        tick();
        exp_cnt = '0;
        total++; if (ready !== 1'b1 || valid_out !== 1'b0) begin bad++; $display("FAIL rm_state got rdy=%0d vo=%0d exp 1/0", ready, valid_out); end
        total++; if (frame_cnt !== exp_cnt) begin bad++; $display("FAIL rm_cnt got=%0d exp=0", frame_cnt); end
        valid = 1'b1;
        tick();
        valid = 1'b0;
        total++; if (n_w1 !== -8'sd115 || n_w3 !== -8'sd105)
            begin bad++; $display("FAIL rm_defaults got w1=%0d w3=%0d exp -115/-105", n_w1, n_w3); end
        repeat (3) tick();
        total++; if (valid_out !== 1'b1 || y !== 8'sd30) begin bad++; $display("FAIL rm_frame got vo=%0d y=%0d exp 1/30", valid_out, y); end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        total++; if (frame_cnt !== exp_cnt) begin bad++; $display("FAIL rm_cnt_after got=%0d exp=%0d", frame_cnt, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_single_frame();
        test_backpressure();
        test_back_to_back();
        test_config();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
